// File: rtl/pipe_ifq_pkg.sv
// rtl/pipe_ifq_pkg.sv - shared CPU constants: opcodes, IF queue depth and NOP encoding
package pipe_ifq_pkg;

    // Default instruction queue depth and the word shown to ID when the queue is empty.
    localparam int          IFQ_DEPTH = 4;
    localparam logic [31:0] NOP_INST  = 32'h0000_0000;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_ANDI  = 6'h0c,
        OP_ORI   = 6'h0d,
        OP_LUI   = 6'h0f,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2b
    } opcode_e;

    // One queue entry: PC+4 in the upper word, instruction in the lower word.
    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] inst;
    } ifq_entry_t;

    function automatic logic [5:0] inst_opcode(input logic [31:0] inst);
        return inst[31:26];
    endfunction

endpackage

// File: rtl/pipe_ifq_ram.sv
// rtl/pipe_ifq_ram.sv - DEPTH x 64 entry storage, one write port, one async read port
module pipe_ifq_ram
    import pipe_ifq_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,     // rising-edge write clock
    input  logic          rst_n,   // async active-low, clears every slot
    input  logic          we,      // write enable
    input  logic [AW-1:0] waddr,   // write slot
    input  ifq_entry_t    wdata,   // entry to store
    input  logic [AW-1:0] raddr,   // read slot
    output ifq_entry_t    rdata    // combinational read data
);

    ifq_entry_t mem_q [DEPTH];
    ifq_entry_t mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/pipe_ifq.sv
// rtl/pipe_ifq.sv - show-ahead instruction fetch queue between IF and ID stages
module pipe_ifq
    import pipe_ifq_pkg::*;
#(
    parameter int          DEPTH = IFQ_DEPTH,
    parameter logic [31:0] NOP   = NOP_INST
) (
    input  logic                     Clk,      // sole clock
    input  logic                     Clrn,     // async active-low reset
    input  logic                     F_Valid,  // fetch offers an entry
    input  logic [31:0]              F_Pc4,    // offered PC+4
    input  logic [31:0]              F_Inst,   // offered instruction
    output logic                     F_Ready,  // queue can accept
    input  logic                     Wirid,    // ID consumes head entry
    input  logic                     Flush,    // redirect: discard everything
    output logic                     D_Valid,  // head entry valid
    output logic [31:0]              D_Pc4,    // head PC+4
    output logic [31:0]              D_Inst,   // head instruction
    output logic [$clog2(DEPTH):0]   Count     // occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic       push;
    logic       pop;
    ifq_entry_t wr_entry;
    ifq_entry_t rd_entry;

    // Ready depends only on registered occupancy, so a full queue never
    // accepts in the same cycle that ID frees a slot.
    assign F_Ready = (count_q < CW'(DEPTH));
    assign D_Valid = (count_q != '0);
    assign Count   = count_q;

    assign push = F_Valid && F_Ready && !Flush;
    assign pop  = Wirid && D_Valid && !Flush;

    assign wr_entry.pc4  = F_Pc4;
    assign wr_entry.inst = F_Inst;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (Flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers are power-of-two wide, so +1 wraps DEPTH-1 -> 0 naturally.
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    pipe_ifq_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (Clk),
        .rst_n (Clrn),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_q),
        .rdata (rd_entry)
    );

    // Stale slot contents are masked so ID sees a clean NOP bubble when empty.
    assign D_Pc4  = D_Valid ? rd_entry.pc4  : 32'h0;
    assign D_Inst = D_Valid ? rd_entry.inst : NOP;

endmodule
